scatter_rd_responder: RTL and testbench
=======================================

# scatter_rd_responder

Read-side responder for the gen_m0 master interface driven by the scatter/gather actions. It accepts burst read commands, queues them in a small command FIFO, and returns INCR bursts of 512-bit beats from an internal preloadable memory window. Beats addressed outside the window carry an error response. It sits at the far end of gen_m0 and stands in for host memory in block-level benches and action bring-up.

## Interface
- AXI_DW, 512, data width; fixed 512 (64-byte beats)
- AXI_AW, 64, address width
- AXI_MIDW, 1, command ID width
- MEM_AW, 10, log2 of window depth in 64-byte words (64 KiB default)
- BASE_ADDR, 64'h0, byte base of the window; 4 KiB aligned
- CMD_DEPTH, 4, command FIFO entries; power of 2
- axi_clk  in  1  clock
- axi_rst  in  1  asynchronous, active-high reset
- gen_m0_maddr  in  AXI_AW  burst start byte address
- gen_m0_mlen  in  8  beats minus 1
- gen_m0_mid  in  AXI_MIDW  command ID
- gen_m0_mread  in  1  read command valid
- gen_m0_mwrite  in  1  write command; never accepted
- gen_m0_mready  in  1  master can take a data beat
- gen_m0_saccept  out  1  command accepted when high with mread
- gen_m0_svalid  out  1  data beat valid
- gen_m0_sdata  out  AXI_DW  beat data
- gen_m0_sid  out  AXI_MIDW  ID of the current burst
- gen_m0_slast  out  1  last beat of the burst
- gen_m0_sresp  out  3  3'b000 OK, 3'b010 out-of-window error
- ld_en  in  1  preload write strobe
- ld_addr  in  MEM_AW  preload word index
- ld_data  in  AXI_DW  preload data
- busy  out  1  FIFO non-empty or burst in flight

## Operation
- Command accept:
  - saccept = !fifo_full & !axi_rst, combinational.
  - A command is pushed at a rising edge where mread & saccept. Pushed fields: maddr, mlen, mid.
  - mwrite is ignored. A command with mwrite=1 and mread=0 is never accepted.
- Data FSM has two states, IDLE and BURST.
  - IDLE -> BURST when the FIFO is non-empty. This pops one entry and loads cur_addr, beats_left = mlen, and sid.
  - BURST issues one beat per cycle in which the output register is empty or is being consumed (svalid & mready).
  - After each issued beat, cur_addr += 64.
  - When beats_left reaches 0 on the final beat:
    - if the FIFO is non-empty, the next entry pops in the same cycle (no idle gap);
    - otherwise the FSM returns to IDLE.
- Address mapping:
  - off = cur_addr - BASE_ADDR, computed at AXI_AW width.
  - In-window when off < 64·2^MEM_AW. In-window beats read RAM word off[MEM_AW+5:6] with sresp = 0.
  - Out-of-window beats (including off wrap below BASE_ADDR) return sdata = 0 and sresp = 3'b010.
  - Window status is evaluated per beat, so a burst can cross from OK into error mid-burst.
  - maddr[5:0] is ignored; beats are always word-aligned.
- RAM:
  - One synchronous read port and one write port (ld_*).
  - On a same-word ld/read collision in the same cycle, the read returns old data.
- Output beat:
  - svalid, sdata, sresp, slast and sid are held stable while svalid & !mready.
  - slast = 1 exactly on beat mlen+1 of each burst.
  - Bursts return in acceptance order.
- busy = !fifo_empty | (state == BURST) | svalid.

## Timing
- Reset (axi_rst high, async): FIFO is emptied and the FSM goes to IDLE. Outputs: svalid=0, slast=0, sresp=0, sid=0, sdata=0, saccept=0 while reset is held, busy=0.
- Reset mid-burst: the remaining beats and queued commands are dropped. svalid falls asynchronously. RAM contents are retained.
- Latency: a command accepted at edge N with an empty FIFO and FSM in IDLE gives its first svalid after edge N+2.
  - N+1: pop and RAM read.
  - N+2: output register loads.
- Throughput is 1 beat per cycle with mready held high, including back-to-back bursts.
- FIFO full: saccept drops in the cycle after the CMD_DEPTH-th accept with no pop.
- Simultaneous push and pop when full: saccept stays low (no bypass).
- Backpressure: mready low stalls the beat pipeline, the RAM read, the address increment and the FIFO pop. No beat is lost or duplicated.

## Test plan
- Preload word i with {8{i[63:0]}} for i = 0..63. Read maddr = BASE_ADDR, mlen = 7, mid = 1 -> 8 beats with data i = 0..7, sid = 1, sresp = 0, slast on beat 8 only, first svalid 2 cycles after accept.
- Hold mread with 6 commands, mlen = 0, while mready = 0 -> exactly 4 accepts, saccept = 0 until a beat drains. Release mready -> 6 single-beat bursts in order.
- Burst at word 2^MEM_AW - 2 with mlen = 3 -> beats 1-2 sresp = 0, beats 3-4 sresp = 3'b010 with sdata = 0. maddr = BASE_ADDR - 64 -> error on every beat.
- Two back-to-back commands (mlen = 63, then mlen = 3) with mready = 1 -> 68 contiguous svalid cycles, slast on beats 64 and 68. Randomly toggle mready -> identical data sequence.
- Assert axi_rst during beat 5 of a 16-beat burst with 2 commands queued -> svalid = 0 immediately, busy = 0. A new read after release returns the preloaded data unchanged.
- mwrite = 1, mread = 0 for 10 cycles -> no accept, no svalid, busy stays 0.

Source files
------------

// File: rtl/scatter_rd_responder.sv
// Read-side responder for gen_m0: queues burst read commands and streams 64-byte
// beats from a preloadable memory window, flagging beats outside the window.
module scatter_rd_responder #(
  parameter int unsigned      AXI_DW    = 512,
  parameter int unsigned      AXI_AW    = 64,
  parameter int unsigned      AXI_MIDW  = 1,
  parameter int unsigned      MEM_AW    = 10,
  parameter logic [AXI_AW-1:0] BASE_ADDR = '0,
  parameter int unsigned      CMD_DEPTH = 4
) (
  input  logic                axi_clk,
  input  logic                axi_rst,
  input  logic [AXI_AW-1:0]   gen_m0_maddr,
  input  logic [7:0]          gen_m0_mlen,
  input  logic [AXI_MIDW-1:0] gen_m0_mid,
  input  logic                gen_m0_mread,
  input  logic                gen_m0_mwrite,
  input  logic                gen_m0_mready,
  output logic                gen_m0_saccept,
  output logic                gen_m0_svalid,
  output logic [AXI_DW-1:0]   gen_m0_sdata,
  output logic [AXI_MIDW-1:0] gen_m0_sid,
  output logic                gen_m0_slast,
  output logic [2:0]          gen_m0_sresp,
  input  logic                ld_en,
  input  logic [MEM_AW-1:0]   ld_addr,
  input  logic [AXI_DW-1:0]   ld_data,
  output logic                busy
);

  localparam int unsigned WA_W  = AXI_AW - 6;
  localparam int unsigned PTR_W = $clog2(CMD_DEPTH);
  localparam int unsigned PW    = PTR_W + 1;

  localparam logic [2:0] RESP_OK  = 3'b000;
  localparam logic [2:0] RESP_ERR = 3'b010;

  // Commands are kept as word addresses; byte offset bits never matter.
  typedef struct packed {
    logic [WA_W-1:0]     wa;
    logic [7:0]          len;
    logic [AXI_MIDW-1:0] id;
  } cmd_t;

  typedef enum logic {IDLE, BURST} state_t;

  state_t              state, state_nx;
  cmd_t                cmd_mem [CMD_DEPTH];
  cmd_t                head;
  logic [PW-1:0]       wr_ptr, rd_ptr;
  logic                fifo_empty, fifo_full;
  logic                push, pop, issue, stall;
  logic [WA_W-1:0]     cur_wa, off_w;
  logic [7:0]          beats_left;
  logic [AXI_MIDW-1:0] cur_id;
  logic                in_win;
  logic [AXI_DW-1:0]   mem [2**MEM_AW];
  logic                unused_in;

  assign unused_in = ^{gen_m0_mwrite, gen_m0_maddr[5:0]};

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                      (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign gen_m0_saccept = !fifo_full && !axi_rst;
  assign push  = gen_m0_mread && gen_m0_saccept;
  assign head  = cmd_mem[rd_ptr[PTR_W-1:0]];
  assign stall = gen_m0_svalid && !gen_m0_mready;
  assign busy  = !fifo_empty || (state == BURST) || gen_m0_svalid;

  // Window check on the word offset; wrap below BASE_ADDR lands out of window.
  assign off_w  = cur_wa - BASE_ADDR[AXI_AW-1:6];
  assign in_win = (off_w[WA_W-1:MEM_AW] == '0);

  // Command FIFO storage
  always_ff @(posedge axi_clk) begin
    if (push) cmd_mem[wr_ptr[PTR_W-1:0]] <= '{wa: gen_m0_maddr[AXI_AW-1:6],
                                              len: gen_m0_mlen, id: gen_m0_mid};
  end

  // Preload write port; reads happen into the output register below.
  always_ff @(posedge axi_clk) begin
    if (ld_en) mem[ld_addr] <= ld_data;
  end

  always_ff @(posedge axi_clk or posedge axi_rst) begin
    if (axi_rst) begin
      state  <= IDLE;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      state <= state_nx;
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
    end
  end

  // Next state: pop on entry from IDLE or chained onto the last beat of a burst.
  always_comb begin
    state_nx = state;
    issue    = 1'b0;
    pop      = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty && !stall) begin
          pop      = 1'b1;
          state_nx = BURST;
        end
      end
      BURST: begin
        if (!stall) begin
          issue = 1'b1;
          if (beats_left == 8'd0) begin
            if (!fifo_empty) pop = 1'b1;
            else             state_nx = IDLE;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Burst address/count tracking
  always_ff @(posedge axi_clk or posedge axi_rst) begin
    if (axi_rst) begin
      cur_wa     <= '0;
      beats_left <= '0;
      cur_id     <= '0;
    end else if (pop) begin
      cur_wa     <= head.wa;
      beats_left <= head.len;
      cur_id     <= head.id;
    end else if (issue) begin
      cur_wa     <= cur_wa + WA_W'(1);
      beats_left <= beats_left - 8'd1;
    end
  end

  // Output beat register doubles as the RAM read register.
  always_ff @(posedge axi_clk or posedge axi_rst) begin
    if (axi_rst) begin
      gen_m0_svalid <= 1'b0;
      gen_m0_sdata  <= '0;
      gen_m0_sresp  <= RESP_OK;
      gen_m0_slast  <= 1'b0;
      gen_m0_sid    <= '0;
    end else if (!stall) begin
      gen_m0_svalid <= issue;
      if (issue) begin
        gen_m0_sdata <= in_win ? mem[off_w[MEM_AW-1:0]] : '0;
        gen_m0_sresp <= in_win ? RESP_OK : RESP_ERR;
        gen_m0_slast <= (beats_left == 8'd0);
        gen_m0_sid   <= cur_id;
      end
    end
  end

endmodule

// File: tb/tb_scatter_rd_responder.sv
// Randomized bench for scatter_rd_responder against a beat-list reference model.
module tb_scatter_rd_responder;

  localparam int unsigned DW   = 512;
  localparam int unsigned AW   = 64;
  localparam int unsigned IDW  = 1;
  localparam int unsigned MAW  = 8;
  localparam int unsigned NW   = 256;
  localparam logic [63:0] BASE = 64'h0000_0000_0002_0000;

  logic           axi_clk = 1'b0;
  logic           axi_rst;
  logic [AW-1:0]  gen_m0_maddr;
  logic [7:0]     gen_m0_mlen;
  logic [IDW-1:0] gen_m0_mid;
  logic           gen_m0_mread;
  logic           gen_m0_mwrite;
  logic           gen_m0_mready = 1'b1;
  logic           gen_m0_saccept;
  logic           gen_m0_svalid;
  logic [DW-1:0]  gen_m0_sdata;
  logic [IDW-1:0] gen_m0_sid;
  logic           gen_m0_slast;
  logic [2:0]     gen_m0_sresp;
  logic           ld_en;
  logic [MAW-1:0] ld_addr;
  logic [DW-1:0]  ld_data;
  logic           busy;

  scatter_rd_responder #(
    .AXI_DW(DW), .AXI_AW(AW), .AXI_MIDW(IDW), .MEM_AW(MAW),
    .BASE_ADDR(BASE), .CMD_DEPTH(4)
  ) dut (
    .axi_clk(axi_clk), .axi_rst(axi_rst),
    .gen_m0_maddr(gen_m0_maddr), .gen_m0_mlen(gen_m0_mlen), .gen_m0_mid(gen_m0_mid),
    .gen_m0_mread(gen_m0_mread), .gen_m0_mwrite(gen_m0_mwrite), .gen_m0_mready(gen_m0_mready),
    .gen_m0_saccept(gen_m0_saccept), .gen_m0_svalid(gen_m0_svalid), .gen_m0_sdata(gen_m0_sdata),
    .gen_m0_sid(gen_m0_sid), .gen_m0_slast(gen_m0_slast), .gen_m0_sresp(gen_m0_sresp),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data), .busy(busy)
  );

  always #5 axi_clk = ~axi_clk;

  typedef struct {
    logic [DW-1:0]  data;
    logic [2:0]     resp;
    logic           last;
    logic [IDW-1:0] id;
  } beat_t;

  beat_t          exp_q[$];
  beat_t          mon_e;
  logic [DW-1:0]  mem_model [NW];
  int             n_cmp = 0, n_err = 0;
  int             acc_cnt = 0, beats_done = 0, run_cur = 0, max_run = 0;
  int             rdy_mode = 1;
  bit             hold_prev = 1'b0;
  logic [DW-1:0]  prev_data;
  logic [IDW+4:0] prev_ctl;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h exp %0h", tag, obs, exp);
    end
  endtask

  // Expected beats of one accepted command, straight from the addressing rules.
  function automatic void model_push(input logic [63:0] addr, input logic [7:0] len,
                                     input logic [IDW-1:0] id);
    logic [63:0] a;
    logic [63:0] off;
    beat_t       b;
    a = {addr[63:6], 6'b0};
    for (int k = 0; k <= int'(len); k++) begin
      off = a + 64'(k) * 64'd64 - BASE;
      if (off < 64'(64 * NW)) begin
        b.data = mem_model[off[13:6]];
        b.resp = 3'b000;
      end else begin
        b.data = '0;
        b.resp = 3'b010;
      end
      b.last = (k == int'(len));
      b.id   = id;
      exp_q.push_back(b);
    end
  endfunction

  always @(posedge axi_clk) begin
    #1;
    case (rdy_mode)
      0:       gen_m0_mready = 1'b0;
      1:       gen_m0_mready = 1'b1;
      default: gen_m0_mready = 1'($urandom_range(0, 1));
    endcase
  end

  // Monitor: sampled mid-cycle, each sample describes the coming rising edge.
  always @(negedge axi_clk) begin
    if (!axi_rst) begin
      if (gen_m0_mread && gen_m0_saccept) begin
        acc_cnt++;
        model_push(gen_m0_maddr, gen_m0_mlen, gen_m0_mid);
      end
      if (hold_prev) begin
        chk("hold_data", gen_m0_sdata, prev_data);
        chk("hold_ctl", DW'({gen_m0_sid, gen_m0_slast, gen_m0_sresp, gen_m0_svalid}),
            DW'(prev_ctl));
      end
      if (gen_m0_svalid && gen_m0_mready) begin
        if (exp_q.size() == 0) begin
          chk("extra_beat", DW'(exp_q.size()), DW'(1));
        end else begin
          mon_e = exp_q.pop_front();
          chk("beat_data", gen_m0_sdata, mon_e.data);
          chk("beat_resp", DW'(gen_m0_sresp), DW'(mon_e.resp));
          chk("beat_last", DW'(gen_m0_slast), DW'(mon_e.last));
          chk("beat_id", DW'(gen_m0_sid), DW'(mon_e.id));
          beats_done++;
        end
      end
      if (gen_m0_svalid) run_cur++;
      else begin
        if (run_cur > max_run) max_run = run_cur;
        run_cur = 0;
      end
      hold_prev = gen_m0_svalid && !gen_m0_mready;
      prev_data = gen_m0_sdata;
      prev_ctl  = {gen_m0_sid, gen_m0_slast, gen_m0_sresp, gen_m0_svalid};
    end else begin
      hold_prev = 1'b0;
      run_cur   = 0;
    end
  end

  task automatic send_cmd(input logic [63:0] a, input logic [7:0] l, input logic [IDW-1:0] id);
    int t;
    gen_m0_maddr = a;
    gen_m0_mlen  = l;
    gen_m0_mid   = id;
    gen_m0_mread = 1'b1;
    for (t = 0; t < 4000; t++) begin
      @(negedge axi_clk);
      if (gen_m0_saccept) break;
    end
    @(posedge axi_clk); #1;
    gen_m0_mread = 1'b0;
    if (t == 4000) chk("cmd_timeout", DW'(gen_m0_saccept), DW'(1));
  endtask

  task automatic wait_idle();
    int t;
    for (t = 0; t < 5000; t++) begin
      @(negedge axi_clk);
      if (!busy && exp_q.size() == 0) break;
    end
    if (t == 5000) chk("idle_timeout", DW'(busy), DW'(0));
    @(posedge axi_clk); #1;
  endtask

  task automatic set_rdy(input int m);
    rdy_mode = m;
    repeat (2) @(posedge axi_clk);
    #2;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout exp finish");
    $fatal(1);
  end

  initial begin
    int t, a0, b0, jj;
    bit got;
    logic [63:0] ra;
    axi_rst = 1'b1; gen_m0_mread = 1'b0; gen_m0_mwrite = 1'b0;
    gen_m0_maddr = '0; gen_m0_mlen = '0; gen_m0_mid = '0;
    ld_en = 1'b0; ld_addr = '0; ld_data = '0;
    repeat (3) @(posedge axi_clk);
    #1;
    chk("rst_saccept", DW'(gen_m0_saccept), DW'(0));
    chk("rst_svalid", DW'(gen_m0_svalid), DW'(0));
    chk("rst_busy", DW'(busy), DW'(0));
    chk("rst_sdata", gen_m0_sdata, DW'(0));
    chk("rst_ctl", DW'({gen_m0_sid, gen_m0_slast, gen_m0_sresp}), DW'(0));
    @(negedge axi_clk); axi_rst = 1'b0;
    @(posedge axi_clk); #1;

    // Preload: words 0..63 hold their index, the rest random.
    for (int i = 0; i < int'(NW); i++) begin
      logic [DW-1:0] d;
      d = (i < 64) ? {8{64'(i)}} : {16{$urandom()}};
      mem_model[i] = d;
      ld_en = 1'b1; ld_addr = MAW'(i); ld_data = d;
      @(posedge axi_clk); #1;
    end
    ld_en = 1'b0;

    // Basic burst and first-beat latency
    send_cmd(BASE, 8'd7, 1'b1);
    for (t = 1; t <= 10; t++) begin
      @(posedge axi_clk); #1;
      if (gen_m0_svalid) break;
    end
    chk("latency", DW'(t), DW'(2));
    wait_idle();

    // FIFO fill while the output is stalled
    set_rdy(0);
    send_cmd(BASE + 64'd640, 8'd0, 1'b0);
    for (t = 0; t < 10; t++) begin
      @(negedge axi_clk);
      if (gen_m0_svalid) break;
    end
    @(posedge axi_clk); #1;
    a0 = acc_cnt;
    jj = 6;
    for (int j = 0; j < 6; j++) begin
      gen_m0_maddr = BASE + 64'(20 + j) * 64'd64;
      gen_m0_mlen  = 8'd0;
      gen_m0_mid   = IDW'(j);
      gen_m0_mread = 1'b1;
      got = 1'b0;
      for (int w = 0; w < 6; w++) begin
        @(negedge axi_clk);
        if (gen_m0_saccept) begin got = 1'b1; break; end
      end
      if (!got) begin
        gen_m0_mread = 1'b0;
        jj = j;
        break;
      end
      @(posedge axi_clk); #1;
      gen_m0_mread = 1'b0;
    end
    chk("acc_stalled", DW'(acc_cnt - a0), DW'(4));
    chk("saccept_full", DW'(gen_m0_saccept), DW'(0));
    set_rdy(1);
    for (int j = jj; j < 6; j++) send_cmd(BASE + 64'(20 + j) * 64'd64, 8'd0, IDW'(j));
    wait_idle();
    chk("acc_total6", DW'(acc_cnt - a0), DW'(6));

    // Window edge, below-base wrap and unaligned start
    send_cmd(BASE + 64'(NW - 2) * 64'd64, 8'd3, 1'b1);
    send_cmd(BASE - 64'd64, 8'd2, 1'b0);
    send_cmd(BASE + 64'd192 + 64'd17, 8'd1, 1'b1);
    wait_idle();

    // Back-to-back bursts, then the same with random backpressure
    max_run = 0;
    send_cmd(BASE, 8'd63, 1'b0);
    send_cmd(BASE + 64'd6400, 8'd3, 1'b1);
    wait_idle();
    chk("run_len", DW'(max_run), DW'(68));
    set_rdy(2);
    b0 = beats_done;
    send_cmd(BASE, 8'd63, 1'b0);
    send_cmd(BASE + 64'd6400, 8'd3, 1'b1);
    wait_idle();
    chk("rand_beats", DW'(beats_done - b0), DW'(68));

    // Reset during beat 5 of a 16-beat burst with two commands queued
    set_rdy(1);
    b0 = beats_done;
    send_cmd(BASE + 64'd1920, 8'd15, 1'b1);
    send_cmd(BASE, 8'd3, 1'b0);
    send_cmd(BASE + 64'd320, 8'd3, 1'b1);
    for (t = 0; t < 200; t++) begin
      @(posedge axi_clk); #2;
      if (beats_done - b0 >= 4) break;
    end
    chk("rst_beat_idx", DW'(beats_done - b0), DW'(4));
    axi_rst = 1'b1;
    #1;
    chk("midrst_svalid", DW'(gen_m0_svalid), DW'(0));
    chk("midrst_busy", DW'(busy), DW'(0));
    exp_q.delete();
    repeat (2) @(negedge axi_clk);
    axi_rst = 1'b0;
    repeat (3) @(posedge axi_clk);
    #1;
    chk("postrst_busy", DW'(busy), DW'(0));
    send_cmd(BASE, 8'd3, 1'b1);
    wait_idle();

    // Write commands are never accepted
    a0 = acc_cnt;
    gen_m0_mwrite = 1'b1;
    gen_m0_maddr  = BASE;
    for (int i = 0; i < 10; i++) begin
      @(negedge axi_clk);
      chk("mw_busy", DW'(busy), DW'(0));
      chk("mw_svalid", DW'(gen_m0_svalid), DW'(0));
    end
    @(posedge axi_clk); #1;
    gen_m0_mwrite = 1'b0;
    chk("mw_acc", DW'(acc_cnt - a0), DW'(0));

    // Random commands under random backpressure
    set_rdy(2);
    for (int i = 0; i < 25; i++) begin
      if ($urandom_range(0, 5) == 0)
        ra = BASE - (64'($urandom_range(1, 4)) << 6);
      else
        ra = BASE + (64'($urandom_range(0, 300)) << 6) + 64'($urandom_range(0, 63));
      send_cmd(ra, 8'($urandom_range(0, 15)), IDW'($urandom_range(0, 1)));
    end
    wait_idle();
    chk("final_q_empty", DW'(exp_q.size()), DW'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
